// File: rtl/colour_key_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | colour_key_pkg                                                       |
// | Shared types and constants for the colour-key tracking pipeline.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package colour_key_pkg;

   localparam int PKG_DW = 8;

   typedef enum logic [1:0] {
      MODE_PASS    = 2'd0,
      MODE_MASK    = 2'd1,
      MODE_OVERLAY = 2'd2,
      MODE_BBOX    = 2'd3
   } mode_e;

   typedef struct packed {
      logic [PKG_DW-1:0] r;
      logic [PKG_DW-1:0] g;
      logic [PKG_DW-1:0] b;
   } rgb_t;

   // Overlay colours as {R,G,B} full-scale flags so they scale with any channel width.
   localparam logic [2:0] C_OVERLAY_RGB = 3'b100;
   localparam logic [2:0] C_OUTLINE_RGB = 3'b010;

endpackage
`default_nettype wire

// File: rtl/colour_key_tracker_pixel_xy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_xy_counter                                                     |
// | Active-pixel x/y position from BLANK_N and VS edges.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pixel_xy_counter #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XW     = $clog2(WIDTH),
   parameter int YW     = $clog2(HEIGHT)
) (
   input  logic          VGA_CLK,
   input  logic          reset_n,
   input  logic          blank_n,
   input  logic          vs,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_end,
   output logic          frame_start
);

   localparam logic [XW-1:0] C_X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] C_Y_LAST = YW'(HEIGHT - 1);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_blank_d;
   logic          r_vs_d;

   assign line_end    = r_blank_d & ~blank_n;
   assign frame_start = r_vs_d & ~vs;
   assign x           = r_x;
   assign y           = r_y;

   // VS history resets high so a low VS right after reset still closes the partial frame.
   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_x       <= '0;
         r_y       <= '0;
         r_blank_d <= 1'b0;
         r_vs_d    <= 1'b1;
      end else begin
         r_blank_d <= blank_n;
         r_vs_d    <= vs;
         if (!vs) begin
            r_x <= '0;
            r_y <= '0;
         end else if (line_end) begin
            r_x <= '0;
            if (r_y != C_Y_LAST) r_y <= r_y + YW'(1);
         end else if (blank_n && (r_x != C_X_LAST)) begin
            r_x <= r_x + XW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/colour_key_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | colour_key_tracker                                                   |
// | Inline colour-window keyer with display modes and per-frame bbox.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module colour_key_tracker #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DW     = 8,
   parameter int XW     = $clog2(WIDTH),
   parameter int YW     = $clog2(HEIGHT),
   parameter int CW     = $clog2(WIDTH * HEIGHT + 1)
) (
   input  logic            VGA_CLK,
   input  logic            reset_n,
   input  logic [DW-1:0]   iVGA_R,
   input  logic [DW-1:0]   iVGA_G,
   input  logic [DW-1:0]   iVGA_B,
   input  logic            iVGA_HS,
   input  logic            iVGA_VS,
   input  logic            iVGA_SYNC_N,
   input  logic            iVGA_BLANK_N,
   input  logic [3*DW-1:0] cfg_lo,
   input  logic [3*DW-1:0] cfg_hi,
   input  logic [1:0]      cfg_mode,
   output logic [DW-1:0]   oVGA_R,
   output logic [DW-1:0]   oVGA_G,
   output logic [DW-1:0]   oVGA_B,
   output logic            oVGA_HS,
   output logic            oVGA_VS,
   output logic            oVGA_SYNC_N,
   output logic            oVGA_BLANK_N,
   output logic            stat_valid,
   output logic            stat_found,
   output logic [CW-1:0]   stat_count,
   output logic [XW-1:0]   stat_xmin,
   output logic [XW-1:0]   stat_xmax,
   output logic [YW-1:0]   stat_ymin,
   output logic [YW-1:0]   stat_ymax
);

   import colour_key_pkg::*;

   function automatic logic [3*DW-1:0] f_expand(input logic [2:0] sel);
      f_expand = {{DW{sel[2]}}, {DW{sel[1]}}, {DW{sel[0]}}};
   endfunction

   logic [3*DW-1:0] r_lo, r_hi;
   mode_e           r_mode;
   logic [CW-1:0]   r_acc_count;
   logic [XW-1:0]   r_acc_xmin, r_acc_xmax;
   logic [YW-1:0]   r_acc_ymin, r_acc_ymax;

   logic [3*DW-1:0] r_s1_rgb;
   logic            r_s1_hs, r_s1_vs, r_s1_sync_n, r_s1_blank_n, r_s1_match;
   logic [XW-1:0]   r_s1_x;
   logic [YW-1:0]   r_s1_y;
   mode_e           r_s1_mode;

   logic [3*DW-1:0] w_in;
   logic [XW-1:0]   w_x;
   logic [YW-1:0]   w_y;
   logic            w_unused_line_end;
   logic            w_frame_start;
   logic            w_match;
   logic            w_on_perim;
   logic [3*DW-1:0] w_rgb;

   assign w_in = {iVGA_R, iVGA_G, iVGA_B};

   pixel_xy_counter #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .XW    (XW),
      .YW    (YW)
   ) u_xy (
      .VGA_CLK    (VGA_CLK),
      .reset_n    (reset_n),
      .blank_n    (iVGA_BLANK_N),
      .vs         (iVGA_VS),
      .x          (w_x),
      .y          (w_y),
      .line_end   (w_unused_line_end),
      .frame_start(w_frame_start)
   );

   // An inverted window (lo > hi) can never satisfy both bounds, so it needs no special case.
   always_comb begin
      w_match = iVGA_BLANK_N;
      for (int c = 0; c < 3; c++) begin
         if ((w_in[c*DW +: DW] < r_lo[c*DW +: DW]) || (w_in[c*DW +: DW] > r_hi[c*DW +: DW]))
            w_match = 1'b0;
      end
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_lo        <= '0;
         r_hi        <= '0;
         r_mode      <= MODE_PASS;
         r_acc_count <= '0;
         r_acc_xmin  <= '0;
         r_acc_xmax  <= '0;
         r_acc_ymin  <= '0;
         r_acc_ymax  <= '0;
         stat_valid  <= 1'b0;
         stat_found  <= 1'b0;
         stat_count  <= '0;
         stat_xmin   <= '0;
         stat_xmax   <= '0;
         stat_ymin   <= '0;
         stat_ymax   <= '0;
      end else begin
         stat_valid <= w_frame_start;
         if (w_frame_start) begin
            r_lo        <= cfg_lo;
            r_hi        <= cfg_hi;
            r_mode      <= mode_e'(cfg_mode);
            stat_found  <= (r_acc_count != '0);
            stat_count  <= r_acc_count;
            stat_xmin   <= r_acc_xmin;
            stat_xmax   <= r_acc_xmax;
            stat_ymin   <= r_acc_ymin;
            stat_ymax   <= r_acc_ymax;
            r_acc_count <= '0;
            r_acc_xmin  <= '0;
            r_acc_xmax  <= '0;
            r_acc_ymin  <= '0;
            r_acc_ymax  <= '0;
         end else if (w_match) begin
            r_acc_count <= r_acc_count + CW'(1);
            if (r_acc_count == '0) begin
               r_acc_xmin <= w_x;
               r_acc_xmax <= w_x;
               r_acc_ymin <= w_y;
               r_acc_ymax <= w_y;
            end else begin
               if (w_x < r_acc_xmin) r_acc_xmin <= w_x;
               if (w_x > r_acc_xmax) r_acc_xmax <= w_x;
               if (w_y < r_acc_ymin) r_acc_ymin <= w_y;
               if (w_y > r_acc_ymax) r_acc_ymax <= w_y;
            end
         end
      end
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_rgb     <= '0;
         r_s1_hs      <= 1'b1;
         r_s1_vs      <= 1'b1;
         r_s1_sync_n  <= 1'b0;
         r_s1_blank_n <= 1'b0;
         r_s1_match   <= 1'b0;
         r_s1_x       <= '0;
         r_s1_y       <= '0;
         r_s1_mode    <= MODE_PASS;
      end else begin
         r_s1_rgb     <= w_in;
         r_s1_hs      <= iVGA_HS;
         r_s1_vs      <= iVGA_VS;
         r_s1_sync_n  <= iVGA_SYNC_N;
         r_s1_blank_n <= iVGA_BLANK_N;
         r_s1_match   <= w_match;
         r_s1_x       <= w_x;
         r_s1_y       <= w_y;
         r_s1_mode    <= r_mode;
      end
   end

   always_comb begin
      w_on_perim = stat_found &&
                   ((((r_s1_x == stat_xmin) || (r_s1_x == stat_xmax)) &&
                     (r_s1_y >= stat_ymin) && (r_s1_y <= stat_ymax)) ||
                    (((r_s1_y == stat_ymin) || (r_s1_y == stat_ymax)) &&
                     (r_s1_x >= stat_xmin) && (r_s1_x <= stat_xmax)));
      w_rgb = r_s1_rgb;
      case (r_s1_mode)
         MODE_PASS:    w_rgb = r_s1_rgb;
         MODE_MASK:    w_rgb = r_s1_match ? f_expand(3'b111) : '0;
         MODE_OVERLAY: if (r_s1_match) w_rgb = f_expand(C_OVERLAY_RGB);
         MODE_BBOX:    if (w_on_perim) w_rgb = f_expand(C_OUTLINE_RGB);
         default:      w_rgb = r_s1_rgb;
      endcase
      if (!r_s1_blank_n) w_rgb = '0;
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         oVGA_R       <= '0;
         oVGA_G       <= '0;
         oVGA_B       <= '0;
         oVGA_HS      <= 1'b1;
         oVGA_VS      <= 1'b1;
         oVGA_SYNC_N  <= 1'b0;
         oVGA_BLANK_N <= 1'b0;
      end else begin
         oVGA_R       <= w_rgb[3*DW-1:2*DW];
         oVGA_G       <= w_rgb[2*DW-1:DW];
         oVGA_B       <= w_rgb[DW-1:0];
         oVGA_HS      <= r_s1_hs;
         oVGA_VS      <= r_s1_vs;
         oVGA_SYNC_N  <= r_s1_sync_n;
         oVGA_BLANK_N <= r_s1_blank_n;
      end
   end

endmodule
`default_nettype wire
